// File: rtl/psum_accumulator.sv
// psum_accumulator
// Sums the MAC array's per-lane partial sums over several input-channel
// passes into saturating per-lane accumulators, then streams the finished
// values out OUT_LANES at a time over a ready/valid interface.
module psum_accumulator #(
    parameter int MAC_NUM    = 256,
    parameter int PSUM_WIDTH = 5,
    parameter int ACC_WIDTH  = 12,
    parameter int OUT_LANES  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [7:0]                      channel_num,
    input  logic [MAC_NUM-1:0]              enable,
    input  logic [PSUM_WIDTH*MAC_NUM-1:0]   psum_in,
    input  logic                            psum_valid,
    output logic [ACC_WIDTH*OUT_LANES-1:0]  out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    localparam int BEATS  = MAC_NUM / OUT_LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [7:0]             r_chanNum;
    logic [7:0]             r_passCnt;
    logic [MAC_NUM-1:0]     r_enable;
    logic [BEAT_W-1:0]      r_beat;
    logic                   r_done;

    logic                   w_startAcc;
    logic                   w_passAcc;
    logic                   w_lastPass;
    logic                   w_beatFire;
    logic                   w_lastFire;

    // Accumulator values viewed as [beat][lane-within-beat] so the drain
    // mux can select a whole beat with the beat index directly.
    logic [ACC_WIDTH-1:0]   w_acc [BEATS][OUT_LANES];

    // State register; reset abandons any job in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode; start and psum_valid are only
    // honoured in the state that expects them, everything else is ignored.
    always_comb begin
        w_nextState = r_state;
        w_startAcc  = 1'b0;
        w_passAcc   = 1'b0;
        w_beatFire  = 1'b0;
        w_lastFire  = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        w_lastPass  = (r_passCnt == (r_chanNum - 8'd1));
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_startAcc  = 1'b1;
                    w_nextState = S_ACCUM;
                end
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (psum_valid) begin
                    w_passAcc = 1'b1;
                    if (w_lastPass) begin
                        w_nextState = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (r_beat == LAST_BEAT);
                if (out_ready) begin
                    w_beatFire = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_lastFire  = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Job bookkeeping: latched job parameters, pass counter, drain beat
    // index and the one-cycle done pulse after the final beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chanNum <= 8'd1;
            r_enable  <= '0;
            r_passCnt <= '0;
            r_beat    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_lastFire;
            if (w_startAcc) begin
                r_chanNum <= (channel_num == 8'd0) ? 8'd1 : channel_num;
                r_enable  <= enable;
                r_passCnt <= '0;
                r_beat    <= '0;
            end
            if (w_passAcc) begin
                r_passCnt <= r_passCnt + 8'd1;
            end
            if (w_lastFire) begin
                r_beat <= '0;
            end else if (w_beatFire) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    assign done = r_done;

    for (genvar gb = 0; gb < BEATS; gb++) begin : g_beat
        for (genvar gl = 0; gl < OUT_LANES; gl++) begin : g_lane
            localparam int LANE = gb * OUT_LANES + gl;

            logic [ACC_WIDTH-1:0] r_acc;
            logic [ACC_WIDTH:0]   w_sum;

            // One spare bit in the sum acts as the overflow flag.
            assign w_sum = {1'b0, r_acc}
                         + {{(ACC_WIDTH + 1 - PSUM_WIDTH){1'b0}},
                            psum_in[LANE*PSUM_WIDTH +: PSUM_WIDTH]};

            // Per-lane saturating accumulate; disabled lanes keep the zero
            // they were cleared to at job start.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_startAcc) begin
                    r_acc <= '0;
                end else if (w_passAcc && r_enable[LANE]) begin
                    r_acc <= w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                              : w_sum[ACC_WIDTH-1:0];
                end
            end

            assign w_acc[gb][gl] = r_acc;
        end
    end

    // Drain mux: present the current beat, forced to zero when not valid.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int j = 0; j < OUT_LANES; j++) begin
                out_data[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_beat][j];
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: randomized passes against a
// plain-arithmetic model of per-lane saturating sums.
module tb_psum_accumulator;

    localparam int MAC_NUM = 256;
    localparam int PW      = 5;
    localparam int AW      = 12;
    localparam int OL      = 16;
    localparam int BEATS   = MAC_NUM / OL;
    localparam int ACC_MAX = (1 << AW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [7:0]           channel_num;
    logic [MAC_NUM-1:0]   enable;
    logic [PW*MAC_NUM-1:0] psum_in;
    logic                 psum_valid;
    logic [AW*OL-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    int total = 0;
    int bad   = 0;

    int unsigned          mAcc [MAC_NUM];
    logic [MAC_NUM-1:0]   mEn;

    psum_accumulator #(
        .MAC_NUM(MAC_NUM), .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .OUT_LANES(OL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .channel_num(channel_num),
        .enable(enable), .psum_in(psum_in), .psum_valid(psum_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [AW*OL-1:0] obs,
                               input logic [AW*OL-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelStart(input logic [MAC_NUM-1:0] en);
        mEn = en;
        for (int i = 0; i < MAC_NUM; i++) mAcc[i] = 0;
    endtask

    task automatic modelPass(input logic [PW*MAC_NUM-1:0] p);
        int unsigned s;
        for (int i = 0; i < MAC_NUM; i++) begin
            if (mEn[i]) begin
                s = mAcc[i] + int'(p[i*PW +: PW]);
                mAcc[i] = (s > ACC_MAX) ? ACC_MAX : s;
            end
        end
    endtask

    function automatic logic [AW*OL-1:0] expBeat(input int b);
        logic [AW*OL-1:0] r;
        r = '0;
        for (int j = 0; j < OL; j++) r[j*AW +: AW] = AW'(mAcc[b*OL + j]);
        return r;
    endfunction

    // mode 0: every lane = val, mode 1: lane i = i mod 32, mode 2: random
    function automatic logic [PW*MAC_NUM-1:0] makePsum(input int mode, input int val);
        logic [PW*MAC_NUM-1:0] p;
        for (int i = 0; i < MAC_NUM; i++) begin
            case (mode)
                0:       p[i*PW +: PW] = PW'(val);
                1:       p[i*PW +: PW] = PW'(i % 32);
                default: p[i*PW +: PW] = PW'($urandom_range(0, 31));
            endcase
        end
        return p;
    endfunction

    function automatic logic [MAC_NUM-1:0] randMask();
        logic [MAC_NUM-1:0] m;
        for (int k = 0; k < MAC_NUM / 32; k++) m[k*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic startJob(input string name, input logic [7:0] cn,
                            input logic [MAC_NUM-1:0] en);
        start       = 1'b1;
        channel_num = cn;
        enable      = en;
        tick();
        start = 1'b0;
        checkOutput({name, "_busy_start"}, busy, 1);
        checkOutput({name, "_valid_start"}, out_valid, 0);
        modelStart(en);
    endtask

    task automatic applyStimulus(input logic [PW*MAC_NUM-1:0] p);
        psum_in    = p;
        psum_valid = 1'b1;
        tick();
        psum_valid = 1'b0;
        modelPass(p);
    endtask

    task automatic runPasses(input string name, input int n, input int mode, input int val);
        for (int k = 0; k < n; k++) begin
            applyStimulus(makePsum(mode, val));
            if (k < n - 1) checkOutput($sformatf("%s_accum_valid%0d", name, k), out_valid, 0);
        end
    endtask

    // readyMode 0: always ready, 1: pattern 1,0,0 repeating, 2: random
    task automatic drainCheck(input string name, input int readyMode, input bit stray);
        int  beat = 0;
        int  cyc  = 0;
        bit  rdy;
        while (beat < BEATS && cyc < 400) begin
            checkOutput($sformatf("%s_valid_b%0d", name, beat), out_valid, 1);
            checkOutput($sformatf("%s_data_b%0d", name, beat), out_data, expBeat(beat));
            checkOutput($sformatf("%s_last_b%0d", name, beat), out_last, (beat == BEATS - 1));
            checkOutput($sformatf("%s_done_b%0d", name, beat), done, 0);
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (stray) begin
                psum_valid = 1'b1;
                psum_in    = makePsum(2, 0);
            end
            tick();
            if (rdy) beat++;
            cyc++;
        end
        out_ready  = 1'b0;
        psum_valid = 1'b0;
        if (beat < BEATS) checkOutput({name, "_drain_timeout"}, beat, BEATS);
        checkOutput({name, "_done_pulse"}, done, 1);
        checkOutput({name, "_valid_end"}, out_valid, 0);
        checkOutput({name, "_busy_end"}, busy, 0);
        checkOutput({name, "_data_end"}, out_data, 0);
        tick();
        checkOutput({name, "_done_clear"}, done, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        channel_num = '0;
        enable      = '0;
        psum_in     = '0;
        psum_valid  = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Job abandoned by reset after 2 of 4 passes, then a clean rerun.
        startJob("abort", 8'd4, '1);
        runPasses("abort", 2, 2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_data", out_data, 0);
        checkOutput("abort_last", out_last, 0);
        tick();
        checkOutput("abort_idle_busy", busy, 0);
        startJob("five", 8'd4, '1);
        runPasses("five", 4, 0, 5);
        drainCheck("five", 0, 1'b0);

        // channel_num 0 behaves as a single pass.
        startJob("zero", 8'd0, '1);
        runPasses("zero", 1, 1, 0);
        drainCheck("zero", 0, 1'b0);

        // Long job that must saturate instead of wrapping.
        startJob("sat", 8'd200, '1);
        runPasses("sat", 200, 0, 31);
        drainCheck("sat", 2, 1'b0);

        // Only even lanes enabled.
        startJob("even", 8'd3, {(MAC_NUM/2){2'b01}});
        runPasses("even", 3, 0, 7);
        drainCheck("even", 0, 1'b0);

        // Backpressure pattern on the drain.
        startJob("bp", 8'd2, '1);
        runPasses("bp", 2, 2, 0);
        drainCheck("bp", 1, 1'b0);

        // Stray psum_valid in IDLE and DRAIN, start during ACCUM.
        for (int k = 0; k < 3; k++) begin
            psum_valid = 1'b1;
            psum_in    = makePsum(2, 0);
            tick();
            checkOutput($sformatf("stray_idle_busy%0d", k), busy, 0);
        end
        psum_valid = 1'b0;
        startJob("stray", 8'd2, '1);
        applyStimulus(makePsum(0, 3));
        start       = 1'b1;
        channel_num = 8'd1;
        enable      = '0;
        tick();
        start = 1'b0;
        checkOutput("stray_restart_busy", busy, 1);
        checkOutput("stray_restart_valid", out_valid, 0);
        applyStimulus(makePsum(0, 3));
        drainCheck("stray", 1, 1'b1);

        // Random jobs: random length, mask, psums, ready and stray traffic.
        for (int n = 0; n < 5; n++) begin
            int cn;
            cn = $urandom_range(0, 6);
            startJob($sformatf("rnd%0d", n), 8'(cn), randMask());
            runPasses($sformatf("rnd%0d", n), (cn == 0) ? 1 : cn, 2, 0);
            drainCheck($sformatf("rnd%0d", n), 2, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
